// File: rtl/mul_seq_pkg.sv
// mul_seq_pkg
// Shared definitions for controllers that drive the 8-bit function unit.
//   FS_*          : function-select encodings understood by the function unit
//   state_t       : sequencer state encoding
//   WIDTH_DEFAULT : default operand width of the multiply sequencer
package mul_seq_pkg;

    localparam int WIDTH_DEFAULT = 8;

    // Function-select encodings. Every block that drives fu_fs takes its
    // codes from here, so the encoding lives in one place.
    localparam logic [3:0] FS_TRA = 4'b0000;
    localparam logic [3:0] FS_ADD = 4'b0010;
    localparam logic [3:0] FS_SHR = 4'b1101;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ADD   = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/fu_mul_seq.sv
// fu_mul_seq
// Multi-cycle unsigned shift-add multiplier. Every addition is done by the
// shared, external function unit. The right shift is done locally in the
// {c_r, acc, q} register chain.
//
// Ports
//   clk, rst       : clock, synchronous active-high reset
//   in_valid/ready : operand handshake (in_a multiplicand, in_b multiplier)
//   out_valid/ready: product handshake (out_p product, out_z product == 0)
//   fu_fs/a/b      : function-select and operands sent to the function unit
//   fu_f/c         : function unit result and carry-out
//
// Configuration
//   MUL_SEQ_SKIP_EN : when defined, iterations whose multiplier bit is 0
//                     skip the ADD cycle. The product does not change.
module fu_mul_seq
    import mul_seq_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_p,
    output logic               out_z,
    output logic [3:0]         fu_fs,
    output logic [WIDTH-1:0]   fu_a,
    output logic [WIDTH-1:0]   fu_b,
    input  logic [WIDTH-1:0]   fu_f,
    input  logic               fu_c
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] m;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] q;
    logic             c_r;
    logic [CW-1:0]    cnt;

    // Function unit drive. It is combinational and is only sampled in ADD.
    // In all other states it sees a harmless transfer of acc.
    always_comb begin
        fu_fs = FS_TRA;
        fu_a  = acc;
        fu_b  = '0;
        if (state == ST_ADD) begin
            fu_fs = FS_ADD;
            fu_b  = q[0] ? m : '0;
        end
    end

    // The product is only exposed in DONE, so out_p/out_z read as 0/1
    // everywhere else, including right after reset.
    always_comb begin
        in_ready  = (state == ST_IDLE);
        out_valid = (state == ST_DONE);
        out_p     = (state == ST_DONE) ? {acc, q} : '0;
        out_z     = (out_p == '0);
    end

    // Sequencer. One iteration is ADD then SHIFT. The carry from ADD is held
    // in c_r and shifted into acc MSB. acc LSB moves into q MSB, so the low
    // half of the product builds up in q as the multiplier bits shift out.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            m     <= '0;
            acc   <= '0;
            q     <= '0;
            c_r   <= 1'b0;
            cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        m   <= in_a;
                        q   <= in_b;
                        acc <= '0;
                        c_r <= 1'b0;
                        cnt <= '0;
`ifdef MUL_SEQ_SKIP_EN
                        state <= in_b[0] ? ST_ADD : ST_SHIFT;
`else
                        state <= ST_ADD;
`endif
                    end
                end
                ST_ADD: begin
                    acc   <= fu_f;
                    c_r   <= fu_c;
                    state <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    {c_r, acc, q} <= {1'b0, c_r, acc, q[WIDTH-1:1]};
                    cnt           <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state <= ST_DONE;
                    end else begin
`ifdef MUL_SEQ_SKIP_EN
                        // q[1] becomes q[0] after this shift. A zero bit
                        // needs no addition, so go straight to another shift.
                        state <= q[1] ? ST_ADD : ST_SHIFT;
`else
                        state <= ST_ADD;
`endif
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fu_mul_seq.sv
// tb_fu_mul_seq
// Directed bench for fu_mul_seq. It includes a behavioural model of the
// shared function unit. Each record holds operands and the hand-computed
// product, zero flag and multiplier popcount. The popcount sets the expected
// latency and ADD count when MUL_SEQ_SKIP_EN is defined.
module tb_fu_mul_seq;
    import mul_seq_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_a = '0;
    logic [7:0]  in_b = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_p;
    logic        out_z;
    logic [3:0]  fu_fs;
    logic [7:0]  fu_a;
    logic [7:0]  fu_b;
    logic [7:0]  fu_f;
    logic        fu_c;

    int assertCount = 0;
    int failCount   = 0;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] p;
        logic        z;
        int          pop;
        int          hold;
        bit          carry;
    } vec_t;

    vec_t vecs[10];

    fu_mul_seq #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_p     (out_p),
        .out_z     (out_z),
        .fu_fs     (fu_fs),
        .fu_a      (fu_a),
        .fu_b      (fu_b),
        .fu_f      (fu_f),
        .fu_c      (fu_c)
    );

    always #5 clk = ~clk;

    // Function unit model: add with carry-out, transfer, shift right.
    always_comb begin
        fu_f = fu_a;
        fu_c = 1'b0;
        case (fu_fs)
            FS_ADD:  {fu_c, fu_f} = {1'b0, fu_a} + {1'b0, fu_b};
            FS_SHR:  fu_f = fu_a >> 1;
            default: ;
        endcase
    end

    // Global watchdog so the bench can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        assertCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic int expLatency(input int pop);
`ifdef MUL_SEQ_SKIP_EN
        return 9 + pop;
`else
        return 17 + 0 * pop;
`endif
    endfunction

    function automatic int expAdds(input int pop);
`ifdef MUL_SEQ_SKIP_EN
        return pop;
`else
        return 8 + 0 * pop;
`endif
    endfunction

    // Run one multiply. It checks latency, product, the function-select
    // trace, the busy in_ready, back-pressure stability and the return to
    // IDLE. in_valid is held high across the DONE handshake to show that it
    // is not accepted before IDLE.
    task automatic applyStimulus(input string name, input vec_t v);
        int lat       = 0;
        int adds      = 0;
        int badFs     = 0;
        int busyReady = 0;
        int unstable  = 0;
        bit carrySeen = 0;
        @(negedge clk);
        checkOutput({name, " ready before accept"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_a     = v.a;
        in_b     = v.b;
        @(posedge clk);
        #1 in_valid = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (out_valid) begin
                lat = k;
                break;
            end
            if (fu_fs == FS_ADD) begin
                adds++;
                if (fu_c) carrySeen = 1;
            end else if (fu_fs != FS_TRA) begin
                badFs++;
            end
            if (in_ready) busyReady++;
        end
        checkOutput({name, " latency"}, 32'(lat), 32'(expLatency(v.pop)));
        if (lat == 0) begin
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            return;
        end
        checkOutput({name, " product"}, 32'(out_p), 32'(v.p));
        checkOutput({name, " zero flag"}, 32'(out_z), 32'(v.z));
        checkOutput({name, " add cycles"}, 32'(adds), 32'(expAdds(v.pop)));
        checkOutput({name, " illegal fs cycles"}, 32'(badFs), 32'd0);
        checkOutput({name, " in_ready while busy"}, 32'(busyReady), 32'd0);
        if (v.carry) checkOutput({name, " carry seen"}, 32'(carrySeen), 32'd1);
        for (int i = 0; i < v.hold; i++) begin
            @(negedge clk);
            if (!out_valid || out_p !== v.p || in_ready) unstable++;
        end
        if (v.hold > 0) checkOutput({name, " hold stability"}, 32'(unstable), 32'd0);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        checkOutput({name, " in_ready after handshake"}, 32'(in_ready), 32'd1);
        checkOutput({name, " out_valid after handshake"}, 32'(out_valid), 32'd0);
        in_valid = 1'b0;
    endtask

    task automatic checkResetOutputs(input string name);
        checkOutput({name, " in_ready"},  32'(in_ready),  32'd1);
        checkOutput({name, " out_valid"}, 32'(out_valid), 32'd0);
        checkOutput({name, " out_p"},     32'(out_p),     32'd0);
        checkOutput({name, " out_z"},     32'(out_z),     32'd1);
        checkOutput({name, " fu_fs"},     32'(fu_fs),     32'(FS_TRA));
        checkOutput({name, " fu_a"},      32'(fu_a),      32'd0);
        checkOutput({name, " fu_b"},      32'(fu_b),      32'd0);
    endtask

    initial begin
        vec_t v;
        //            a      b      p          z     pop hold carry
        vecs[0] = '{8'd13,  8'd11,  16'h008F, 1'b0, 3, 0, 0};
        vecs[1] = '{8'd255, 8'd255, 16'hFE01, 1'b0, 8, 0, 1};
        vecs[2] = '{8'd0,   8'd200, 16'h0000, 1'b1, 3, 0, 0};
        vecs[3] = '{8'd7,   8'd9,   16'h003F, 1'b0, 2, 5, 0};
        vecs[4] = '{8'd1,   8'd1,   16'h0001, 1'b0, 1, 0, 0};
        vecs[5] = '{8'd128, 8'd2,   16'h0100, 1'b0, 1, 0, 0};
        vecs[6] = '{8'd100, 8'd3,   16'h012C, 1'b0, 2, 0, 0};
        vecs[7] = '{8'd255, 8'd0,   16'h0000, 1'b1, 0, 0, 0};
        vecs[8] = '{8'd1,   8'd128, 16'h0080, 1'b0, 1, 0, 0};
        vecs[9] = '{8'd200, 8'd200, 16'h9C40, 1'b0, 3, 0, 0};

        $display("[TB] reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkResetOutputs("reset");

        for (int i = 0; i < 10; i++) begin
            applyStimulus($sformatf("vec%0d %0dx%0d", i, vecs[i].a, vecs[i].b), vecs[i]);
        end

        // Reset in the middle of an operation. rst is raised during cycle T+6.
        $display("[TB] mid-operation reset");
        @(negedge clk);
        in_valid = 1'b1;
        in_a     = 8'd100;
        in_b     = 8'd3;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (6) @(negedge clk);
        checkOutput("busy before mid reset", 32'(in_ready), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkResetOutputs("mid reset");
        repeat (25) begin
            @(negedge clk);
            if (out_valid) break;
        end
        checkOutput("no product after mid reset", 32'(out_valid), 32'd0);

        v = '{8'd2, 8'd2, 16'h0004, 1'b0, 1, 0, 0};
        applyStimulus("post reset 2x2", v);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 assertCount, failCount);
        $finish;
    end

endmodule
